// File: rtl/pcpi_insn_loader.sv
// Byte-serial instruction loader feeding a PCPI coprocessor port.
// Optional ISSUE timeout enabled by defining LOADER_TIMEOUT_EN.
module pcpi_insn_loader #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    input  logic        pcpi_ready,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_wr,
    output logic        resp_err,
    output logic        resp_timeout
);

    localparam logic [6:0] CUSTOM0 = 7'b0001011;

    typedef enum logic [1:0] {
        COLLECT,
        ISSUE,
        RESP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] byte_cnt;
    logic       accept;
    logic       last_byte;
    logic       opc_ok;
    logic       opc_bad;
    logic       issue_done;
    logic       issue_to;
    logic       to_expire;

    assign byte_ready = (state == COLLECT);
    assign accept     = byte_valid && byte_ready;
    assign last_byte  = accept && (byte_cnt == 2'd3);
    // byte 0 already sits in pcpi_insn when byte 3 arrives
    assign opc_ok     = last_byte && (pcpi_insn[6:0] == CUSTOM0);
    assign opc_bad    = last_byte && (pcpi_insn[6:0] != CUSTOM0);
    assign issue_done = (state == ISSUE) && pcpi_ready;
    assign issue_to   = (state == ISSUE) && !pcpi_ready && to_expire;

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;

    assign to_expire = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state != ISSUE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_timeout <= 1'b0;
        end else if (issue_done || opc_bad) begin
            resp_timeout <= 1'b0;
        end else if (issue_to) begin
            resp_timeout <= 1'b1;
        end
    end
`else
    assign to_expire    = 1'b0;
    assign resp_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: begin
                if (opc_ok) begin
                    state_nxt = ISSUE;
                end else if (opc_bad) begin
                    state_nxt = RESP;
                end
            end
            ISSUE: begin
                if (issue_done || issue_to) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COLLECT;
            byte_cnt   <= 2'd0;
            pcpi_insn  <= '0;
            pcpi_valid <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_wr    <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pcpi_valid <= (state_nxt == ISSUE);
            resp_valid <= (state_nxt == RESP);
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                pcpi_insn[{byte_cnt, 3'b000} +: 8] <= byte_in;
            end
            if (issue_done) begin
                resp_data <= pcpi_rd;
                resp_wr   <= pcpi_wr;
                resp_err  <= 1'b0;
            end else if (issue_to) begin
                resp_data <= '0;
                resp_wr   <= 1'b0;
                resp_err  <= 1'b0;
            end else if (opc_bad) begin
                resp_data <= '0;
                resp_wr   <= 1'b0;
                resp_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pcpi_insn_loader.sv
// Directed scoreboard bench for pcpi_insn_loader.
// Define LOADER_TIMEOUT_EN to also exercise the ISSUE timeout.
module tb_pcpi_insn_loader;

`ifdef LOADER_TIMEOUT_EN
    localparam int TO   = 4;
    localparam int WAIT = 3;
`else
    localparam int TO   = 64;
    localparam int WAIT = 7;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic        pcpi_ready = 1'b0;
    logic        pcpi_wr = 1'b0;
    logic [31:0] pcpi_rd = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_wr;
    logic        resp_err;
    logic        resp_timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] data;
        logic        wr;
        logic        err;
        logic        to;
        int          vc;
    } exp_t;

    exp_t q[$];

    pcpi_insn_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .pcpi_valid   (pcpi_valid),
        .pcpi_insn    (pcpi_insn),
        .pcpi_ready   (pcpi_ready),
        .pcpi_wr      (pcpi_wr),
        .pcpi_rd      (pcpi_rd),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_wr      (resp_wr),
        .resp_err     (resp_err),
        .resp_timeout (resp_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] insn, input logic [31:0] data,
                        input logic wr, input logic err, input logic to,
                        input int vc);
        exp_t e;
        e.insn = insn;
        e.data = data;
        e.wr   = wr;
        e.err  = err;
        e.to   = to;
        e.vc   = vc;
        q.push_back(e);
    endtask

    // Monitor: pops one expectation per response strobe
    int   vcnt = 0;
    logic prev_resp = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            vcnt      = 0;
            prev_resp = 1'b0;
        end else begin
            if (prev_resp) chk("resp_one_cycle", resp_valid, 0);
            if (pcpi_valid) vcnt++;
            if (resp_valid) begin
                chk("resp_expected", q.size() > 0, 1);
                chk("rdy_in_resp", byte_ready, 0);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("resp_insn", pcpi_insn, e.insn);
                    chk("resp_data", resp_data, e.data);
                    chk("resp_wr", resp_wr, e.wr);
                    chk("resp_err", resp_err, e.err);
                    chk("resp_timeout", resp_timeout, e.to);
                    chk("valid_cycles", vcnt, e.vc);
                end
                vcnt = 0;
            end
            prev_resp = resp_valid;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int   c = 0;
        logic r = 1'b0;
        byte_valid = 1'b1;
        byte_in    = b;
        do begin
            @(negedge clk);
            r = byte_ready;
            @(posedge clk);
            #1;
            c++;
        end while (!r && c < 50);
        chk("byte_accept", r, 1);
        byte_valid = 1'b0;
    endtask

    task automatic send_insn(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic drain();
        int c = 0;
        while (q.size() != 0 && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drain", q.size(), 0);
    endtask

    logic [7:0] bb [8];
    int         idx;
    int         low;
    logic       rdy;

    initial begin
        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_byte_ready", byte_ready, 1);
        chk("rst_pcpi_valid", pcpi_valid, 0);
        chk("rst_pcpi_insn", pcpi_insn, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_status", {resp_wr, resp_err, resp_timeout}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // immediate completion; pcpi_ready high during COLLECT is ignored
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = 32'h0;
        push(32'h0002800B, 32'h0, 1, 0, 0, 1);
        send_insn(32'h0002800B);
        chk("issue_latency", pcpi_valid, 1);
        drain();

        // bad opcode: no issue, error response with zero data
        pcpi_rd = 32'h12345678;
        push(32'h00000033, 32'h0, 0, 1, 0, 0);
        send_insn(32'h00000033);
        chk("bad_no_issue", pcpi_valid, 0);
        drain();
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;

        // delayed completion; stray bytes during ISSUE are ignored
        push(32'h0000700B, 32'hDEADBEEF, 1, 0, 0, WAIT + 1);
        send_insn(32'h0000700B);
        byte_valid = 1'b1;
        byte_in    = 8'hFF;
        repeat (WAIT) begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = 32'h0;
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("hold_data", resp_data, 32'hDEADBEEF);
        chk("hold_wr", resp_wr, 1);

        // back-to-back with byte_valid held high
        bb = '{8'h0B, 8'h00, 8'h01, 8'h00, 8'h8B, 8'h10, 8'hC3, 8'hA5};
        pcpi_ready = 1'b1;
        pcpi_rd    = 32'h0BADF00D;
        push(32'h0001000B, 32'h0BADF00D, 0, 0, 0, 1);
        push(32'hA5C3108B, 32'h0BADF00D, 0, 0, 0, 1);
        idx = 0;
        low = 0;
        byte_valid = 1'b1;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            byte_in = bb[idx];
            @(negedge clk);
            rdy = byte_ready;
            @(posedge clk);
            #1;
            if (rdy) idx++;
            else low++;
        end
        byte_valid = 1'b0;
        chk("b2b_bytes", idx, 8);
        chk("b2b_low_cycles", low, 2);
        drain();
        pcpi_ready = 1'b0;

        // reset mid-collection, then a fresh instruction
        send_byte(8'h0B);
        send_byte(8'h70);
        rst = 1'b1;
        #1;
        chk("midcol_rst_insn", pcpi_insn, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pcpi_ready = 1'b1;
        pcpi_rd    = 32'h00001234;
        push(32'h0000000B, 32'h00001234, 0, 0, 0, 1);
        send_insn(32'h0000000B);
        drain();
        pcpi_ready = 1'b0;

        // reset mid-ISSUE: no response may follow
        send_insn(32'h0000000B);
        chk("midiss_valid", pcpi_valid, 1);
        rst = 1'b1;
        #1;
        chk("midiss_rst_valid", pcpi_valid, 0);
        chk("midiss_rst_ready", byte_ready, 1);
        chk("midiss_rst_insn", pcpi_insn, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midiss_no_resp", resp_valid, 0);

`ifdef LOADER_TIMEOUT_EN
        pcpi_rd = 32'hFFFF0000;
        push(32'h0000300B, 32'h0, 0, 0, 1, TO);
        send_insn(32'h0000300B);
        drain();
        @(posedge clk);
        #1;
        chk("to_valid_drop", pcpi_valid, 0);
        chk("to_hold", resp_timeout, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
